// File: rtl/imem_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_dmem_arbiter
//
// Shares one single-ported unified memory between the fetch stage
// (instruction port) and the memory stage (data port) of a 5-stage core.
// Each memory transaction is a req/ack handshake bounded by a wait-state
// timeout. Data requests normally win arbitration, but a fetch that has
// watched STARVE_LIMIT consecutive data grants is forced through next.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   if_req/if_addr      fetch request and PC (held until if_valid)
//   if_rdata/if_valid   fetched word (registered) and its one-cycle pulse
//   if_stall            fetch stall to the hazard unit (combinational)
//   d_req/d_we/d_addr/d_wdata/d_be
//                       data request and payload (held until d_valid)
//   d_rdata/d_valid     load data (registered) and its one-cycle pulse
//   d_stall             data stall to the hazard unit (combinational)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be
//                       registered memory request, stable for a transaction
//   mem_rdata/mem_ack   memory read data and completion
//   err                 one-cycle pulse when a transaction times out
// -----------------------------------------------------------------------------
module imem_dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [3:0]  STARVE_MAX  = 4'(STARVE_LIMIT);
    localparam logic [7:0]  WAIT_LAST   = 8'(TIMEOUT - 1);
    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;

    state_t      state_r;
    logic [3:0]  starve_cnt_r;
    logic [7:0]  wait_cnt_r;
    logic        data_wins_s;
    logic        timed_out_s;

    // Data wins unless the waiting fetch has already been passed over too often.
    assign data_wins_s = d_req & ~(if_req & (starve_cnt_r == STARVE_MAX));
    // Abort on the last allowed wait cycle if the memory still has not answered.
    assign timed_out_s = ~mem_ack & (wait_cnt_r == WAIT_LAST);

    // Stalls reach the hazard unit in the same cycle, so they stay combinational.
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req  & ~d_valid;

    // Arbitration FSM with all memory-side and port-side outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            starve_cnt_r <= 4'd0;
            wait_cnt_r   <= 8'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_be       <= 4'd0;
            if_rdata     <= 32'd0;
            if_valid     <= 1'b0;
            d_rdata      <= 32'd0;
            d_valid      <= 1'b0;
            err          <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            case (state_r)
                IDLE: begin
                    wait_cnt_r <= 8'd0;
                    if (data_wins_s) begin
                        state_r   <= GNT_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_we ? d_be : 4'hF;
                        // Only a fetch actually left waiting counts toward starvation.
                        if (if_req) begin
                            if (starve_cnt_r != STARVE_MAX) begin
                                starve_cnt_r <= starve_cnt_r + 4'd1;
                            end else begin
                                starve_cnt_r <= starve_cnt_r;
                            end
                        end else begin
                            starve_cnt_r <= 4'd0;
                        end
                    end else if (if_req) begin
                        state_r      <= GNT_I;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr;
                        mem_wdata    <= 32'd0;
                        mem_be       <= 4'hF;
                        starve_cnt_r <= 4'd0;
                    end else begin
                        state_r      <= IDLE;
                        starve_cnt_r <= 4'd0;
                    end
                end
                GNT_I: begin
                    if (mem_ack || timed_out_s) begin
                        state_r    <= IDLE;
                        mem_req    <= 1'b0;
                        wait_cnt_r <= 8'd0;
                        // A flushed fetch still lands in if_rdata, but is not announced.
                        if_valid   <= if_req;
                        err        <= timed_out_s;
                        if_rdata   <= mem_ack ? mem_rdata : NOP_INSN;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                GNT_D: begin
                    if (mem_ack || timed_out_s) begin
                        state_r    <= IDLE;
                        mem_req    <= 1'b0;
                        wait_cnt_r <= 8'd0;
                        d_valid    <= d_req;
                        err        <= timed_out_s;
                        // A completed store returns nothing; an aborted access reads as zero.
                        if (timed_out_s) begin
                            d_rdata <= 32'd0;
                        end else if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end else begin
                            d_rdata <= d_rdata;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_dmem_arbiter
//
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model (who owns the memory, how long it has waited, how many
// data grants a waiting fetch has seen) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_imem_dmem_arbiter;

    localparam int SL = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    imem_dmem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner 0 = nobody, 1 = fetch, 2 = data.
    int          m_owner;
    int          m_waited;
    int          m_passed_over;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_ifr;
    logic [31:0] m_dr;
    logic        m_ifv;
    logic        m_dv;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model over one clock edge using the inputs presented to it.
    task automatic model_edge();
        logic data_first;
        logic finished;
        m_ifv = 1'b0;
        m_dv  = 1'b0;
        m_err = 1'b0;
        if (!reset) begin
            m_owner = 0; m_waited = 0; m_passed_over = 0;
            m_req = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
            m_be = 4'd0; m_ifr = 32'd0; m_dr = 32'd0;
        end else if (m_owner == 0) begin
            m_waited   = 0;
            data_first = d_req && !(if_req && m_passed_over >= SL);
            if (data_first) begin
                m_owner = 2; m_req = 1'b1; m_we = d_we; m_addr = d_addr;
                m_wdata = d_wdata; m_be = d_we ? d_be : 4'hF;
                m_passed_over = if_req ? ((m_passed_over + 1 > SL) ? SL : m_passed_over + 1) : 0;
            end else if (if_req) begin
                m_owner = 1; m_req = 1'b1; m_we = 1'b0; m_addr = if_addr;
                m_be = 4'hF; m_passed_over = 0;
            end else begin
                m_passed_over = 0;
            end
        end else begin
            finished = mem_ack || (m_waited == TO - 1);
            if (finished) begin
                m_err = !mem_ack;
                if (m_owner == 1) begin
                    m_ifr = mem_ack ? mem_rdata : 32'h0000_0013;
                    m_ifv = if_req;
                end else begin
                    if (!mem_ack) m_dr = 32'd0;
                    else if (!m_we) m_dr = mem_rdata;
                    m_dv = d_req;
                end
                m_owner = 0; m_req = 1'b0; m_waited = 0;
            end else begin
                m_waited++;
            end
        end
    endtask

    task automatic compare_all();
        chk("mem_req", mem_req, m_req);
        if (m_req) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_be", mem_be, m_be);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_valid", if_valid, m_ifv);
        chk("d_valid", d_valid, m_dv);
        chk("err", err, m_err);
        chk("if_rdata", if_rdata, m_ifr);
        chk("d_rdata", d_rdata, m_dr);
        chk("if_stall", if_stall, if_req & ~m_ifv);
        chk("d_stall", d_stall, d_req & ~m_dv);
    endtask

    // One cycle: edge, model update, sample 1ns later, return at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    string obs_seq;
    logic  prev_req;
    logic  hang;

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        step();
        step();
        chk("rst_mem_req", mem_req, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        reset = 1'b1;
        step();

        // Fetch only, acked in the first grant cycle.
        if_req = 1'b1; if_addr = 32'h100;
        #1 chk("t1_stall_pre", if_stall, 32'd1);
        step();
        chk("t1_mem_req", mem_req, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we", mem_we, 32'd0);
        chk("t1_mem_be", mem_be, 32'hF);
        chk("t1_stall_gnt", if_stall, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        chk("t1_if_valid", if_valid, 32'd1);
        chk("t1_if_rdata", if_rdata, 32'h0050_0093);
        chk("t1_mem_req_low", mem_req, 32'd0);
        chk("t1_stall_done", if_stall, 32'd0);
        if_req = 1'b0; mem_ack = 1'b0;
        step();

        // Simultaneous fetch and store: store first, fetch after one idle cycle.
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        step();
        chk("t2_mem_we", mem_we, 32'd1);
        chk("t2_mem_be", mem_be, 32'h3);
        chk("t2_mem_addr", mem_addr, 32'h2000);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        chk("t2_d_valid", d_valid, 32'd1);
        chk("t2_d_rdata_store", d_rdata, 32'd0);
        d_req = 1'b0; mem_ack = 1'b0;
        step();
        chk("t2_fetch_addr", mem_addr, 32'h200);
        chk("t2_fetch_req", mem_req, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        step();
        chk("t2_if_valid", if_valid, 32'd1);
        if_req = 1'b0; mem_ack = 1'b0;
        step();

        // Both held continuously: grants must come as D,D,I,D,D,I.
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        obs_seq = "";
        prev_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (mem_req && !prev_req) obs_seq = {obs_seq, (mem_addr == 32'h300) ? "I" : "D"};
            prev_req = mem_req;
        end
        checks++;
        assert (obs_seq == "DDIDDI") else begin
            failures++;
            $error("FAIL t3_grant_order observed=%s expected=DDIDDI", obs_seq);
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        step();
        chk("t3_d_rdata", d_rdata, 32'h1111_1111);

        // Load never acked: abort exactly TIMEOUT cycles after the grant.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        step();
        chk("t4_gnt", mem_req, 32'd1);
        for (int i = 0; i < TO - 1; i++) begin
            step();
            chk("t4_still_waiting", mem_req, 32'd1);
        end
        step();
        chk("t4_err", err, 32'd1);
        chk("t4_d_valid", d_valid, 32'd1);
        chk("t4_d_rdata", d_rdata, 32'd0);
        chk("t4_mem_req", mem_req, 32'd0);
        d_req = 1'b0;
        step();
        chk("t4_err_once", err, 32'd0);

        // Fetch flushed mid-transaction, then a pending load goes next.
        if_req = 1'b1; if_addr = 32'h600;
        step();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7000;
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        chk("t5_no_if_valid", if_valid, 32'd0);
        chk("t5_if_rdata", if_rdata, 32'hCAFE_F00D);
        chk("t5_mem_req", mem_req, 32'd0);
        mem_ack = 1'b0;
        step();
        chk("t5_d_gnt", mem_req, 32'd1);
        chk("t5_d_addr", mem_addr, 32'h7000);
        mem_ack = 1'b1; mem_rdata = 32'h2222_3333;
        step();
        chk("t5_d_valid", d_valid, 32'd1);
        d_req = 1'b0; mem_ack = 1'b0;
        step();

        // Reset during an unacked data grant loses the transaction.
        d_req = 1'b1; d_addr = 32'h8000;
        step();
        chk("t6_gnt", mem_req, 32'd1);
        reset = 1'b0;
        step();
        chk("t6_mem_req", mem_req, 32'd0);
        chk("t6_mem_addr", mem_addr, 32'd0);
        chk("t6_d_rdata", d_rdata, 32'd0);
        chk("t6_if_rdata", if_rdata, 32'd0);
        reset = 1'b1; d_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t6_no_d_valid", d_valid, 32'd0);
            chk("t6_no_err", err, 32'd0);
        end

        // Randomized traffic against the model.
        hang = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (m_ifv || (if_req && $urandom_range(0, 49) == 0)) begin
                if_req = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (m_dv || (d_req && $urandom_range(0, 49) == 0)) begin
                d_req = 1'b0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
                d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
            end
            if (m_req && m_waited == 0) hang = ($urandom_range(0, 9) == 0);
            mem_ack   = m_req ? (!hang && $urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            reset     = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
